// File: rtl/bpu_update_ctrl.sv
// Branch-update scheduler: orders verify results, squashes wrong-path ones,
// serialises BHT/RAS writes and drives the one-cycle fetch redirect.
package bpu_pkg;
    typedef enum logic [2:0] {
        Branch_None   = 3'd0,
        Branch_Call   = 3'd1,
        Branch_Return = 3'd2,
        Branch_Cond   = 3'd3,
        Branch_Jump   = 3'd4
    } br_type_t;

    localparam logic [1:0] CNT_NT  = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_T   = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [2:0]  br_type;
        logic [1:0]  count;
    } upd_entry_t;
endpackage

module bpu_update_ctrl
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_exception,
    input  logic [1:0]       vr_valid,
    input  logic [1:0][31:0] vr_pc,
    input  logic [1:0]       vr_is_taken,
    input  logic [1:0][31:0] vr_correct_target,
    input  logic [1:0]       vr_predict_sucess,
    input  logic [1:0][2:0]  vr_br_type,
    input  logic [1:0][1:0]  vr_count,
    output logic             vr_ready,
    output logic             bht_we,
    output logic [9:0]       bht_waddr,
    output logic [21:0]      bht_wtag,
    output logic [31:0]      bht_wtarget,
    output logic [2:0]       bht_wbr_type,
    output logic [1:0]       bht_wcount,
    output logic             ras_push,
    output logic             ras_pop,
    output logic [31:0]      ras_push_data,
    output logic             redirect_valid,
    output logic [31:0]      redirect_target,
    output logic             pred_enable
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, CORRECTION} state_t;

    state_t      state_q, state_d;
    logic [31:0] redirect_target_q, redirect_target_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    upd_entry_t  mem_q [DEPTH];
    upd_entry_t  mem_d [DEPTH];

    logic [AW:0]   occ;
    logic          empty, idle;
    logic          take0, take1, mis0, mis1, enq0, enq1;
    logic [AW-1:0] widx1;
    upd_entry_t    e0, e1, hd;

    function automatic logic [1:0] next_count(
        input logic [1:0] c,
        input logic       taken,
        input logic       ok
    );
        if (!ok)
            return taken ? CNT_WT : CNT_WNT;
        if (taken)
            return (c == CNT_T) ? c : c + 2'd1;
        return (c == CNT_NT) ? c : c - 2'd1;
    endfunction

    always_comb begin
        occ      = wptr_q - rptr_q;
        empty    = (wptr_q == rptr_q);
        vr_ready = (occ <= (AW+1)'(DEPTH - 2));
        idle     = (state_q == IDLE);

        // a slot-0 mispredict makes slot 1 wrong-path
        take0 = vr_valid[0] & vr_ready & idle & ~flush_exception;
        mis0  = take0 & ~vr_predict_sucess[0];
        take1 = vr_valid[1] & vr_ready & idle & ~flush_exception & ~mis0;
        mis1  = take1 & ~vr_predict_sucess[1];
        enq0  = take0 & (vr_br_type[0] != Branch_None);
        enq1  = take1 & (vr_br_type[1] != Branch_None);

        e0.pc      = vr_pc[0];
        e0.target  = vr_correct_target[0];
        e0.br_type = vr_br_type[0];
        e0.count   = next_count(vr_count[0], vr_is_taken[0],
                                vr_predict_sucess[0]);
        e1.pc      = vr_pc[1];
        e1.target  = vr_correct_target[1];
        e1.br_type = vr_br_type[1];
        e1.count   = next_count(vr_count[1], vr_is_taken[1],
                                vr_predict_sucess[1]);

        widx1 = wptr_q[AW-1:0] + AW'(enq0);
        mem_d = mem_q;
        if (enq0)
            mem_d[wptr_q[AW-1:0]] = e0;
        if (enq1)
            mem_d[widx1] = e1;

        wptr_d = wptr_q + (AW+1)'(enq0) + (AW+1)'(enq1);
        rptr_d = rptr_q + (AW+1)'(!empty);

        state_d           = IDLE;
        redirect_target_d = redirect_target_q;
        if (mis0 | mis1) begin
            state_d           = CORRECTION;
            redirect_target_d = mis0 ? vr_correct_target[0]
                                     : vr_correct_target[1];
        end

        if (flush_exception) begin
            wptr_d            = '0;
            rptr_d            = '0;
            state_d           = IDLE;
            redirect_target_d = '0;
        end
    end

    always_comb begin
        hd            = empty ? '0 : mem_q[rptr_q[AW-1:0]];
        bht_we        = !empty;
        bht_waddr     = {hd.pc[11:3], 1'b0};
        bht_wtag      = hd.pc[31:10];
        bht_wtarget   = hd.target;
        bht_wbr_type  = hd.br_type;
        bht_wcount    = hd.count;
        ras_push      = bht_we && (hd.br_type == Branch_Call);
        ras_pop       = bht_we && (hd.br_type == Branch_Return);
        ras_push_data = bht_we ? hd.pc + 32'd8 : '0;
        redirect_valid  = (state_q == CORRECTION);
        pred_enable     = (state_q == IDLE);
        redirect_target = redirect_target_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            redirect_target_q <= '0;
            wptr_q            <= '0;
            rptr_q            <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q           <= state_d;
            redirect_target_q <= redirect_target_d;
            wptr_q            <= wptr_d;
            rptr_q            <= rptr_d;
            mem_q             <= mem_d;
        end
    end
endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Scoreboard bench for bpu_update_ctrl: directed verify results in,
// BHT/RAS writes and redirects checked by a negedge monitor.
module tb_bpu_update_ctrl;
    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_CALL = 3'd1;
    localparam logic [2:0] T_RET  = 3'd2;
    localparam logic [2:0] T_COND = 3'd3;

    typedef struct {
        logic [9:0]  addr;
        logic [21:0] tag;
        logic [31:0] tgt;
        logic [2:0]  ty;
        logic [1:0]  cnt;
        logic        push;
        logic        pop;
        logic [31:0] pdata;
    } exp_w_t;

    logic             clk;
    logic             reset;
    logic             flush_exception;
    logic [1:0]       vr_valid;
    logic [1:0][31:0] vr_pc;
    logic [1:0]       vr_is_taken;
    logic [1:0][31:0] vr_correct_target;
    logic [1:0]       vr_predict_sucess;
    logic [1:0][2:0]  vr_br_type;
    logic [1:0][1:0]  vr_count;
    logic             vr_ready;
    logic             bht_we;
    logic [9:0]       bht_waddr;
    logic [21:0]      bht_wtag;
    logic [31:0]      bht_wtarget;
    logic [2:0]       bht_wbr_type;
    logic [1:0]       bht_wcount;
    logic             ras_push;
    logic             ras_pop;
    logic [31:0]      ras_push_data;
    logic             redirect_valid;
    logic [31:0]      redirect_target;
    logic             pred_enable;

    int tests = 0;
    int fails = 0;
    exp_w_t      sb_q[$];
    logic [31:0] rd_q[$];

    bpu_update_ctrl #(.DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush_exception   (flush_exception),
        .vr_valid          (vr_valid),
        .vr_pc             (vr_pc),
        .vr_is_taken       (vr_is_taken),
        .vr_correct_target (vr_correct_target),
        .vr_predict_sucess (vr_predict_sucess),
        .vr_br_type        (vr_br_type),
        .vr_count          (vr_count),
        .vr_ready          (vr_ready),
        .bht_we            (bht_we),
        .bht_waddr         (bht_waddr),
        .bht_wtag          (bht_wtag),
        .bht_wtarget       (bht_wtarget),
        .bht_wbr_type      (bht_wbr_type),
        .bht_wcount        (bht_wcount),
        .ras_push          (ras_push),
        .ras_pop           (ras_pop),
        .ras_push_data     (ras_push_data),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .pred_enable       (pred_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_w_t mk(input logic [31:0] pc,
                                  input logic [31:0] tgt,
                                  input logic [2:0] ty,
                                  input logic [1:0] cnt);
        exp_w_t e;
        e.addr  = {pc[11:3], 1'b0};
        e.tag   = pc[31:10];
        e.tgt   = tgt;
        e.ty    = ty;
        e.cnt   = cnt;
        e.push  = (ty == T_CALL);
        e.pop   = (ty == T_RET);
        e.pdata = pc + 32'd8;
        return e;
    endfunction

    function automatic exp_w_t mkc(input logic [9:0] addr,
                                   input logic [21:0] tag,
                                   input logic [31:0] tgt,
                                   input logic [2:0] ty,
                                   input logic [1:0] cnt,
                                   input logic push,
                                   input logic [31:0] pdata);
        exp_w_t e;
        e.addr  = addr;
        e.tag   = tag;
        e.tgt   = tgt;
        e.ty    = ty;
        e.cnt   = cnt;
        e.push  = push;
        e.pop   = 1'b0;
        e.pdata = pdata;
        return e;
    endfunction

    task automatic set_slot(input int i, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic ok, input logic [2:0] ty,
                            input logic [1:0] cnt);
        vr_valid[i]          = 1'b1;
        vr_pc[i]             = pc;
        vr_is_taken[i]       = tk;
        vr_correct_target[i] = tgt;
        vr_predict_sucess[i] = ok;
        vr_br_type[i]        = ty;
        vr_count[i]          = cnt;
    endtask

    // hold the presented slots until the DUT can take them, then one edge
    task automatic present();
        int n = 0;
        while (!(vr_ready && pred_enable) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL present_timeout: got ready=%0b expected 1",
                     vr_ready);
        end
        @(posedge clk); #1;
        vr_valid = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (bht_we && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got bht_we=1 expected 0");
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bht_we) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_write_pc_tag", {10'd0, bht_wtag}, 32'hFFFF_FFFF);
                end else begin
                    exp_w_t e;
                    e = sb_q.pop_front();
                    chk("waddr", {22'd0, bht_waddr}, {22'd0, e.addr});
                    chk("wtag", {10'd0, bht_wtag}, {10'd0, e.tag});
                    chk("wtarget", bht_wtarget, e.tgt);
                    chk("wbr_type", {29'd0, bht_wbr_type}, {29'd0, e.ty});
                    chk("wcount", {30'd0, bht_wcount}, {30'd0, e.cnt});
                    chk("ras_push", {31'd0, ras_push}, {31'd0, e.push});
                    chk("ras_pop", {31'd0, ras_pop}, {31'd0, e.pop});
                    if (e.push)
                        chk("ras_push_data", ras_push_data, e.pdata);
                end
            end else begin
                chk("ras_idle", {30'd0, ras_push, ras_pop}, 32'd0);
            end
            if (redirect_valid) begin
                if (rd_q.size() == 0)
                    chk("unexpected_redirect", redirect_target, 32'hFFFF_FFFF);
                else
                    chk("redirect_target", redirect_target, rd_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        flush_exception = 1'b0;
        vr_valid = '0;
        vr_pc = '0;
        vr_is_taken = '0;
        vr_correct_target = '0;
        vr_predict_sucess = '0;
        vr_br_type = '0;
        vr_count = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bht_we", {31'd0, bht_we}, 32'd0);
        chk("rst_vr_ready", {31'd0, vr_ready}, 32'd1);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_pred_enable", {31'd0, pred_enable}, 32'd1);
        chk("rst_redirect_target", redirect_target, 32'd0);
        chk("rst_ras_push_data", ras_push_data, 32'd0);
        chk("rst_wtag_wcount", {8'd0, bht_wtag, bht_wcount}, 32'd0);
        reset = 1'b0;
        step();

        // saturating taken increment, first write one cycle after enqueue
        sb_q.push_back(mkc(10'h002, 22'h2FF004, 32'hBFC0_2000,
                           T_COND, 2'b11, 1'b0, 32'd0));
        set_slot(0, 32'hBFC0_1008, 1'b1, 32'hBFC0_2000, 1'b1, T_COND, 2'b11);
        present();
        chk("first_write_latency", {31'd0, bht_we}, 32'd1);
        step();

        // dual issue: saturating decrement then a Call with RAS push
        sb_q.push_back(mkc(10'h010, 22'h200000, 32'h8000_0048,
                           T_COND, 2'b00, 1'b0, 32'd0));
        sb_q.push_back(mkc(10'h040, 22'h200000, 32'h8000_1000,
                           T_CALL, 2'b11, 1'b1, 32'h8000_0108));
        set_slot(0, 32'h8000_0040, 1'b0, 32'h8000_0048, 1'b1, T_COND, 2'b00);
        set_slot(1, 32'h8000_0100, 1'b1, 32'h8000_1000, 1'b1, T_CALL, 2'b10);
        present();
        chk("dual_first", {31'd0, bht_we}, 32'd1);
        step();
        chk("dual_second_consecutive", {31'd0, ras_push}, 32'd1);

        // slot0 mispredict squashes slot1; CORRECTION ignores new results
        sb_q.push_back(mkc(10'h100, 22'h200001, 32'h8000_2000,
                           T_COND, 2'b10, 1'b0, 32'd0));
        rd_q.push_back(32'h8000_2000);
        set_slot(0, 32'h8000_0400, 1'b1, 32'h8000_2000, 1'b0, T_COND, 2'b01);
        set_slot(1, 32'h8000_0408, 1'b1, 32'h8000_0500, 1'b1, T_COND, 2'b11);
        present();
        chk("corr_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("corr_pred_enable", {31'd0, pred_enable}, 32'd0);
        set_slot(0, 32'h8000_0800, 1'b1, 32'hDEAD_0000, 1'b0, T_COND, 2'b00);
        step();
        vr_valid = '0;
        chk("corr_one_cycle", {31'd0, redirect_valid}, 32'd0);
        chk("corr_back_idle", {31'd0, pred_enable}, 32'd1);

        // Return pops RAS; Branch_None is never enqueued
        sb_q.push_back(mk(32'h8000_0600, 32'h8000_1234, T_RET, 2'b11));
        set_slot(0, 32'h8000_0600, 1'b1, 32'h8000_1234, 1'b1, T_RET, 2'b10);
        set_slot(1, 32'h8000_0608, 1'b0, 32'h8000_0610, 1'b1, T_NONE, 2'b00);
        present();

        // slot1 mispredict redirects to its own target
        sb_q.push_back(mk(32'h8000_0700, 32'h8000_0708, T_COND, 2'b01));
        sb_q.push_back(mk(32'h8000_0710, 32'h8000_0718, T_COND, 2'b01));
        rd_q.push_back(32'h8000_0718);
        set_slot(0, 32'h8000_0700, 1'b0, 32'h8000_0708, 1'b1, T_COND, 2'b10);
        set_slot(1, 32'h8000_0710, 1'b0, 32'h8000_0718, 1'b0, T_COND, 2'b11);
        present();
        step();
        drain();

        // fill: occupancy 3 drops vr_ready, order preserved across wrap
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 2; s++) begin
                logic [31:0] pc;
                pc = 32'h8000_1000 + 32'(8 * (2 * k + s));
                sb_q.push_back(mk(pc, 32'h9000_0000 + pc[7:0], T_COND, 2'b10));
                set_slot(s, pc, 1'b1, 32'h9000_0000 + pc[7:0], 1'b1,
                         T_COND, 2'b01);
            end
            present();
            if (k == 1)
                chk("full_ready_low", {31'd0, vr_ready}, 32'd0);
        end
        drain();

        // flush during CORRECTION with two entries queued
        sb_q.push_back(mk(32'h8000_0200, 32'h8000_0a00, T_COND, 2'b11));
        sb_q.push_back(mk(32'h8000_0208, 32'h8000_0a08, T_COND, 2'b11));
        set_slot(0, 32'h8000_0200, 1'b1, 32'h8000_0a00, 1'b1, T_COND, 2'b11);
        set_slot(1, 32'h8000_0208, 1'b1, 32'h8000_0a08, 1'b1, T_COND, 2'b11);
        present();
        rd_q.push_back(32'h8000_3000);
        set_slot(0, 32'h8000_0300, 1'b1, 32'h8000_3000, 1'b0, T_COND, 2'b00);
        present();
        chk("flush_pre_corr", {31'd0, redirect_valid}, 32'd1);
        flush_exception = 1'b1;
        step();
        flush_exception = 1'b0;
        chk("flush_fifo_empty", {31'd0, bht_we}, 32'd0);
        chk("flush_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("flush_redirect_target", redirect_target, 32'd0);
        chk("flush_ready", {31'd0, vr_ready}, 32'd1);
        step();

        // reset with three entries queued
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                logic [31:0] pc;
                pc = 32'h8000_5000 + 32'(8 * (2 * k + s));
                sb_q.push_back(mk(pc, pc + 32'h100, T_COND, 2'b11));
                set_slot(s, pc, 1'b1, pc + 32'h100, 1'b1, T_COND, 2'b11);
            end
            present();
        end
        chk("pre_reset_ready", {31'd0, vr_ready}, 32'd0);
        reset = 1'b1;
        #1;
        sb_q.delete();
        chk("midrst_bht_we", {31'd0, bht_we}, 32'd0);
        chk("midrst_ready", {31'd0, vr_ready}, 32'd1);
        chk("midrst_redirect", {31'd0, redirect_valid}, 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("postrst_empty", {31'd0, bht_we}, 32'd0);

        repeat (3) step();
        chk("sb_leftover", sb_q.size(), 32'd0);
        chk("rd_leftover", rd_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
